divider_64bit_seq: RTL and testbench

// - Sequential radix-2 restoring unsigned divider: the responder (core) side of the divide-request stream.
// - Two independent AXI-stream-style operand channels (dividend, divisor) with tvalid/tready; one result channel.
// - Result packs {quotient, remainder}; drop-in for the IP divider used by the start-pulse divider wrappers.

---
 rtl/divider_pkg.sv | 7 +
 rtl/divider_64bit_seq_slot.sv | 26 ++
 rtl/divider_64bit_seq.sv | 73 +++++++
 tb/tb_divider_64bit_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared width, FSM state encoding and result field offsets for the sequential divider.
package divider_pkg;
  localparam int WIDTH = 64;
  localparam int QUO_LSB = WIDTH;
  localparam int REM_LSB = 0;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/divider_64bit_seq_slot.sv
// axis_operand_slot: one-entry operand register; ready while empty, emptied by the consumer's clear.
module axis_operand_slot #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tvalid,
  output logic             tready,
  input  logic [WIDTH-1:0] tdata,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  assign tready = !full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (tvalid && tready) begin
      full <= 1'b1;
      data <= tdata;
    end
  end
endmodule

// File: rtl/divider_64bit_seq.sv
// divider_64bit_seq: radix-2 restoring unsigned divider with AXI-stream operand and result channels.
module divider_64bit_seq #(
  parameter int WIDTH = divider_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tuser
);
  import divider_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, d, a_data, b_data, rn, qn;
  logic [WIDTH:0] sh, diff;
  logic a_full, b_full, load, ge;
  axis_operand_slot #(.WIDTH(WIDTH)) u_dividend (
    .clk(clk), .rst_n(rst_n), .tvalid(s_axis_dividend_tvalid), .tready(s_axis_dividend_tready),
    .tdata(s_axis_dividend_tdata), .clear(load), .full(a_full), .data(a_data)
  );
  axis_operand_slot #(.WIDTH(WIDTH)) u_divisor (
    .clk(clk), .rst_n(rst_n), .tvalid(s_axis_divisor_tvalid), .tready(s_axis_divisor_tready),
    .tdata(s_axis_divisor_tdata), .clear(load), .full(b_full), .data(b_data)
  );
  assign load = (state == IDLE) && a_full && b_full;
  // Partial remainder stays below D, so the shifted value minus D borrows exactly when it is smaller than D.
  assign sh   = {r, q[WIDTH-1]};
  assign diff = sh - {1'b0, d};
  assign ge   = !diff[WIDTH];
  assign rn   = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign qn   = {q[WIDTH-2:0], ge};
  assign m_axis_dout_tvalid = (state == DONE);
  always_comb begin
    state_nx = state;
    state_nx = load ? CALC
             : (state == CALC && cnt == '0) ? DONE
             : (state == DONE && m_axis_dout_tready) ? IDLE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      m_axis_dout_tdata <= '0;
      m_axis_dout_tuser <= 1'b0;
    end else if (load) begin
      r <= '0;
      q <= a_data;
      d <= b_data;
      cnt <= CW'(WIDTH - 1);
      m_axis_dout_tuser <= (b_data == '0);
    end else if (state == CALC) begin
      r <= rn;
      q <= qn;
      cnt <= cnt - 1'b1;
      if (cnt == '0) m_axis_dout_tdata <= {qn, rn};
    end
  end
endmodule

// File: tb/tb_divider_64bit_seq.sv
// tb_divider_64bit_seq: scoreboard bench for the sequential divider (latency, skid, back-pressure, reset, random).
module tb_divider_64bit_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, m_ready = 1'b1, rnd = 1'b0;
  logic a_ready, b_ready, dout_valid, dout_user;
  logic [63:0] a_data = '0, b_data = '0;
  logic [127:0] dout_data;
  logic [128:0] exp_q[$];
  int tests = 0, fails = 0, cyc = 0;
  divider_64bit_seq dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_dividend_tvalid(a_valid), .s_axis_dividend_tready(a_ready), .s_axis_dividend_tdata(a_data),
    .s_axis_divisor_tvalid(b_valid), .s_axis_divisor_tready(b_ready), .s_axis_divisor_tdata(b_data),
    .m_axis_dout_tvalid(dout_valid), .m_axis_dout_tready(m_ready),
    .m_axis_dout_tdata(dout_data), .m_axis_dout_tuser(dout_user)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd) begin #1; m_ready = ($urandom_range(0, 3) != 0); end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [128:0] model(input logic [63:0] a, input logic [63:0] b);
    return (b == 0) ? {64'hFFFF_FFFF_FFFF_FFFF, a, 1'b1} : {a / b, a % b, 1'b0};
  endfunction
  always @(negedge clk) begin
    logic [128:0] e;
    if (rst_n && dout_valid && m_ready) begin
      if (exp_q.size() == 0) chk("spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("quotient", dout_data[127:64], e[128:65]);
        chk("remainder", dout_data[63:0], e[64:1]);
        chk("dz_flag", dout_user, e[0]);
      end
    end
  end
  task automatic wait_accept();
    logic ah, bh;
    int t = 0;
    while ((a_valid || b_valid) && t < 2000) begin
      @(negedge clk);
      ah = a_valid && a_ready;
      bh = b_valid && b_ready;
      @(posedge clk); #1;
      if (ah) a_valid = 1'b0;
      if (bh) b_valid = 1'b0;
      t++;
    end
    if (a_valid || b_valid) begin
      chk("accept_timeout", 0, 1);
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
  endtask
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    exp_q.push_back(model(a, b));
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    wait_accept();
  endtask
  task automatic wait_valid(output int at);
    int t = 0;
    do begin @(negedge clk); t++; end while (!dout_valid && t < 300);
    at = cyc;
  endtask
  task automatic run_lat(input logic [63:0] a, input logic [63:0] b);
    int n, at;
    @(posedge clk); #1;
    n = cyc;
    send(a, b);
    wait_valid(at);
    chk("latency", at - n, 66);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin
    int n, at, viol;
    logic [128:0] e1;
    logic [63:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_user", dout_user, 0);
    run_lat(64'd100, 64'd7);
    run_lat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_lat(64'd5, 64'd9);
    run_lat(64'd12345, 64'd0);
    @(posedge clk); #1;
    n = cyc;
    exp_q.push_back(model(64'd500, 64'd13));
    a_data = 64'd500; b_data = 64'd13; a_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_valid = 1'b0;
      if (k == 10) b_valid = 1'b1;
      if (k == 11) b_valid = 1'b0;
      @(negedge clk);
      if (k == 1 || k == 11 || k == 12) chk($sformatf("stagger_ready_%0d", k), a_ready, (k <= 11) ? 0 : 1);
    end
    wait_valid(at);
    chk("stagger_latency", at - n, 76);
    @(posedge clk); #1;
    m_ready = 1'b0;
    e1 = model(64'hDEAD_BEEF_0000_1234, 64'd977);
    send(64'hDEAD_BEEF_0000_1234, 64'd977);
    wait_valid(at);
    @(posedge clk); #1;
    send(64'd1_000_000, 64'd333);
    exp_q.push_back(model(64'd77, 64'd8));
    a_data = 64'd77; b_data = 64'd8; a_valid = 1'b1; b_valid = 1'b1;
    viol = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!dout_valid || dout_data !== {e1[128:65], e1[64:1]}) viol++;
    end
    chk("held_stable", viol, 0);
    chk("held_data", dout_data, {e1[128:65], e1[64:1]});
    chk("stall_a_ready", a_ready, 0);
    chk("stall_b_ready", b_ready, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_accept();
    drain();
    @(posedge clk); #1;
    a_data = 64'd1000; b_data = 64'd3; a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_a_ready", a_ready, 1);
    chk("midrst_b_ready", b_ready, 1);
    run_lat(64'd81, 64'd9);
    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1, 2, 3: b = b >> $urandom_range(32, 63);
        4, 5: a = a >> $urandom_range(0, 40);
        default: ;
      endcase
      send(a, b);
    end
    rnd = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
